fft_stage_sequencer: RTL and testbench

Sequencer that drives the single radix-2 FFT butterfly datapath through a complete N-point in-place transform. It walks every stage and every butterfly, presents operand addresses and twiddle index per butterfly, and handshakes with the datapath until each result is written back. It sits between the top-level control (start/abort) and the butterfly datapath plus its sample RAM.

---
 rtl/fft_stage_sequencer.sv | 103 ++++++++++
 tb/tb_fft_stage_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: walks every stage/butterfly of an in-place radix-2 FFT and handshakes each with the datapath.
// Define FFT_SEQ_DIF_EN for decimation-in-frequency ordering; DIT ordering otherwise.
module fft_stage_sequencer #(
  parameter int LOG2N = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             bf_req,
  input  logic             bf_ack,
  input  logic             bf_done,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output logic [LOG2N-2:0] tw_idx,
  output logic [2:0]       stage,
  output logic             busy,
  output logic             done
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, DONE} state_t;
  state_t           state_q, state_d;
  logic [2:0]       s_q, s_d;
  logic [LOG2N-2:0] b_q, b_d;
  logic [LOG2N-1:0] bx, half, j, g, a;
  logic [LOG2N-2:0] tw;
  logic [3:0]       sh;
  logic             live;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
    end
  end
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    if (abort) begin
      state_d = IDLE;
      s_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = ISSUE;
          s_d     = '0;
          b_d     = '0;
        end
        ISSUE: if (bf_ack) state_d = bf_done ? NEXT : WAIT;
        WAIT:  if (bf_done) state_d = NEXT;
        NEXT: begin
          if (b_q != '1) begin
            b_d     = b_q + (LOG2N-1)'(1);
            state_d = ISSUE;
          end else if (s_q != 3'(LOG2N-1)) begin
            s_d     = s_q + 3'd1;
            b_d     = '0;
            state_d = ISSUE;
          end else begin
            state_d = DONE;
          end
        end
        DONE: begin
          state_d = IDLE;
          s_d     = '0;
          b_d     = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // Operand indices derive only from the s/b registers, so no input reaches an output.
  always_comb begin
    bx = {1'b0, b_q};
    sh = 4'(LOG2N-1) - {1'b0, s_q};
`ifdef FFT_SEQ_DIF_EN
    half = {1'b1, {(LOG2N-1){1'b0}}} >> s_q;
    j    = bx & (half - LOG2N'(1));
    g    = bx >> sh;
    a    = (g << (sh + 4'd1)) | j;
    tw   = (LOG2N-1)'(j << s_q);
`else
    half = LOG2N'(1) << s_q;
    j    = bx & (half - LOG2N'(1));
    g    = bx >> s_q;
    a    = (g << ({1'b0, s_q} + 4'd1)) | j;
    tw   = (LOG2N-1)'(j << sh);
`endif
    live   = state_q != IDLE;
    addr_a = live ? a : '0;
    addr_b = live ? a + half : '0;
    tw_idx = live ? tw : '0;
    stage  = s_q;
    bf_req = state_q == ISSUE;
    busy   = live;
    done   = state_q == DONE;
  end
endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: randomized handshake bench against an arithmetic model of the butterfly ordering.
module tb_fft_stage_sequencer;
  localparam int L = 3;
  localparam int N = 1 << L;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, bf_ack = 1'b0, bf_done = 1'b0;
  logic       bf_req, busy, done;
  logic [L-1:0] addr_a, addr_b;
  logic [L-2:0] tw_idx;
  logic [2:0] stage;
  logic       start2 = 1'b0;
  logic       bf_req2, busy2, done2;
  logic [1:0] addr_a2, addr_b2;
  logic [0:0] tw_idx2;
  logic [2:0] stage2;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  fft_stage_sequencer #(.LOG2N(L)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .bf_req(bf_req), .bf_ack(bf_ack), .bf_done(bf_done),
    .addr_a(addr_a), .addr_b(addr_b), .tw_idx(tw_idx),
    .stage(stage), .busy(busy), .done(done)
  );
  // Small instance answers with a zero-wait datapath: ack in ISSUE, done in WAIT.
  fft_stage_sequencer #(.LOG2N(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
    .bf_req(bf_req2), .bf_ack(bf_req2), .bf_done(busy2 & ~bf_req2),
    .addr_a(addr_a2), .addr_b(addr_b2), .tw_idx(tw_idx2),
    .stage(stage2), .busy(busy2), .done(done2)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [23:0] ref_bf(input int lg, input int s, input int b);
    int half, j, a, t;
`ifdef FFT_SEQ_DIF_EN
    half = (1 << lg) >> (s + 1);
    j    = b % half;
    t    = j * (1 << s);
`else
    half = 1 << s;
    j    = b % half;
    t    = j * ((1 << (lg - 1)) / half);
`endif
    a = (b / half) * 2 * half + j;
    return {8'(a), 8'(a + half), 8'(t)};
  endfunction
  function automatic logic [23:0] obs();
    return {8'(addr_a), 8'(addr_b), 8'(tw_idx)};
  endfunction
  task automatic chk_idle(input string tag);
    check({tag, "_req"}, bf_req, 0);
    check({tag, "_addr_a"}, addr_a, 0);
    check({tag, "_addr_b"}, addr_b, 0);
    check({tag, "_tw"}, tw_idx, 0);
    check({tag, "_stage"}, stage, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask
  task automatic run_xform(input int hold, input int same, input int kill_at, input bit kill_rst, output int cyc);
    int k, t;
    bit both;
    k = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check("busy_start", busy, 1);
    for (int s = 0; s < L; s++) begin
      for (int b = 0; b < N / 2; b++) begin
        t = 0;
        while (!bf_req && t < 20) begin
          @(negedge clk);
          cyc++;
          t++;
        end
        check("req_up", bf_req, 1);
        check("addr", obs(), ref_bf(L, s, b));
        check("stage", stage, s);
        repeat (hold < 0 ? int'($urandom_range(0, 3)) : hold) begin
          bf_done = 1'($urandom_range(0, 1));
          start = 1'b1;
          @(negedge clk);
          cyc++;
          bf_done = 1'b0;
          start = 1'b0;
          check("hold_req", bf_req, 1);
          check("hold_addr", obs(), ref_bf(L, s, b));
        end
        both = (k != kill_at) && (same == 2 || (same == 1 && $urandom_range(0, 1) == 1));
        bf_ack = 1'b1;
        bf_done = both;
        @(negedge clk);
        cyc++;
        bf_ack = 1'b0;
        bf_done = 1'b0;
        check("req_drop", bf_req, 0);
        if (k == kill_at) begin
          if (kill_rst) rst = 1'b1;
          else abort = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          abort = 1'b0;
          chk_idle("kill");
          repeat (3) begin
            @(negedge clk);
            check("kill_no_done", done, 0);
            check("kill_busy", busy, 0);
          end
          return;
        end
        if (!both) begin
          repeat (hold < 0 ? int'($urandom_range(0, 2)) : 0) begin
            bf_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            cyc++;
            bf_ack = 1'b0;
            check("wait_req", bf_req, 0);
          end
          bf_done = 1'b1;
          @(negedge clk);
          cyc++;
          bf_done = 1'b0;
        end
        k++;
      end
    end
    check("pre_done", done, 0);
    @(negedge clk);
    cyc++;
    check("done_up", done, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("busy_end", busy, 0);
  endtask
  initial begin
    int cyc, idx;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk_idle("start_abort");
    run_xform(0, 0, -1, 1'b0, cyc);
    check("zw_cycles", cyc, 37);
    run_xform(0, 2, -1, 1'b0, cyc);
    check("same_cycles", cyc, 25);
    run_xform(5, 0, -1, 1'b0, cyc);
    repeat (3) run_xform(-1, 1, -1, 1'b0, cyc);
    run_xform(0, 0, 6, 1'b1, cyc);
    run_xform(0, 0, -1, 1'b0, cyc);
    check("after_rst_cycles", cyc, 37);
    run_xform(-1, 1, int'($urandom_range(8, 11)), 1'b0, cyc);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    idx = 0;
    for (int c = 1; c <= 14; c++) begin
      if (bf_req2) begin
        if (idx < 4) check("l2_addr", {8'(addr_a2), 8'(addr_b2), 8'(tw_idx2)}, ref_bf(2, idx / 2, idx % 2));
        idx++;
      end
      check("l2_done", done2, c == 13);
      @(negedge clk);
    end
    check("l2_count", idx, 4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
